stream_mux_rr: RTL and testbench

Parametrised N:1 streaming multiplexer, successor to the team's 2:1 combinational mux. It selects among NUM_CH valid/ready input channels by round-robin arbitration and drives one registered output stage. It sits between parallel producers and a single shared consumer (bus, UART TX, display path). Output carries data plus the source channel index.

---
 rtl/stream_mux_rr.sv | 117 +++++++++++
 tb/tb_stream_mux_rr.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream multiplexer with round-robin arbitration and a registered output stage.
// Define MUX_FORCE_SEL_EN to add force_en/force_sel, which pin the grant to one channel.
module stream_mux_rr #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         in_valid,
    input  logic [NUM_CH*WIDTH-1:0]   in_data,
    output logic [NUM_CH-1:0]         in_ready,
`ifdef MUX_FORCE_SEL_EN
    input  logic                      force_en,
    input  logic [CH_W-1:0]           force_sel,
`endif
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [CH_W-1:0]           out_ch,
    input  logic                      out_ready
);

    logic                out_valid_q, out_valid_d;
    logic [WIDTH-1:0]    out_data_q, out_data_d;
    logic [CH_W-1:0]     out_ch_q, out_ch_d;
    logic [CH_W-1:0]     last_q, last_d;

    logic [NUM_CH-1:0]   eligible;
    logic [NUM_CH-1:0]   grant;
    logic [CH_W-1:0]     grant_idx;
    logic                grant_found;
    logic                load_en;
    logic                xfer;
    logic                rotate;
    logic [WIDTH-1:0]    ch_data [NUM_CH];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign ch_data[gi]  = in_data[gi*WIDTH +: WIDTH];
            assign in_ready[gi] = grant[gi] && load_en;
        end
    endgenerate

    assign load_en = !out_valid_q || out_ready;

`ifdef MUX_FORCE_SEL_EN
    always_comb begin
        eligible = '0;
        rotate   = 1'b1;
        if (force_en) begin
            rotate = 1'b0;
            // Out-of-range selections leave every channel ineligible.
            if (int'(force_sel) < NUM_CH)
                eligible[force_sel] = in_valid[force_sel];
        end else begin
            eligible = in_valid;
        end
    end
`else
    assign eligible = in_valid;
    assign rotate   = 1'b1;
`endif

    // Scan starts just after the last granted channel and wraps at NUM_CH.
    always_comb begin
        int idx;
        grant       = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        idx         = 0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = int'(last_q) + i;
            if (idx >= NUM_CH)
                idx = idx - NUM_CH;
            if (!grant_found && eligible[idx]) begin
                grant_found = 1'b1;
                grant_idx   = CH_W'(idx);
                grant[idx]  = 1'b1;
            end
        end
    end

    assign xfer = grant_found && load_en;

    always_comb begin
        out_valid_d = xfer || (out_valid_q && !out_ready);
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        last_d      = last_q;
        if (xfer) begin
            out_data_d = ch_data[grant_idx];
            out_ch_d   = grant_idx;
            if (rotate)
                last_d = grant_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            last_q      <= CH_W'(NUM_CH - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            last_q      <= last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: reset, single channel, fairness, backpressure, async reset, forced select.
module tb_stream_mux_rr;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 8;
    localparam int CH_W   = 2;

    logic                    clk;
    logic                    rst_n;
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_ready;
    logic                    out_valid;
    logic [WIDTH-1:0]        out_data;
    logic [CH_W-1:0]         out_ch;
    logic                    out_ready;
`ifdef MUX_FORCE_SEL_EN
    logic                    force_en;
    logic [CH_W-1:0]         force_sel;
`endif

    int checks_total;
    int checks_passed;

    stream_mux_rr #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
`ifdef MUX_FORCE_SEL_EN
        .force_en  (force_en),
        .force_sel (force_sel),
`endif
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        if (obs !== exp)
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        else begin
            checks_passed++;
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic set_data(input int k, input logic [WIDTH-1:0] v);
        in_data[k*WIDTH +: WIDTH] = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        rst_n     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef MUX_FORCE_SEL_EN
        force_en  = 1'b0;
        force_sel = '0;
`endif

        // Reset then idle
        do_reset();
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_data", 32'(out_data), 32'd0);
        check("reset out_ch", 32'(out_ch), 32'd0);
        for (int i = 0; i < 10; i++) begin
            check("idle in_ready", 32'(in_ready), 32'd0);
            tick();
            check("idle out_valid", 32'(out_valid), 32'd0);
        end

        // Single channel 2
        in_valid  = 4'b0100;
        set_data(2, 8'hA5);
        out_ready = 1'b1;
        #1;
        check("single in_ready", 32'(in_ready), 32'b0100);
        tick();
        in_valid = '0;
        check("single out_valid", 32'(out_valid), 32'd1);
        check("single out_data", 32'(out_data), 32'hA5);
        check("single out_ch", 32'(out_ch), 32'd2);

        // Fairness from a fresh pointer
        do_reset();
        for (int k = 0; k < NUM_CH; k++) set_data(k, 8'(8'h10 + k));
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 7) in_valid = '0;
            check("fair out_valid", 32'(out_valid), 32'd1);
            check("fair out_ch", 32'(out_ch), 32'(i % 4));
            check("fair out_data", 32'(out_data), 32'(8'h10 + (i % 4)));
        end
        tick();
        check("fair drain out_valid", 32'(out_valid), 32'd0);

        // Backpressure on channel 1
        in_valid = 4'b0010;
        set_data(1, 8'h11);
        #1;
        check("bp first in_ready", 32'(in_ready), 32'b0010);
        tick();
        set_data(1, 8'h22);
        out_ready = 1'b0;
        check("bp first out_data", 32'(out_data), 32'h11);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp stall in_ready", 32'(in_ready), 32'd0);
            tick();
            check("bp stall out_valid", 32'(out_valid), 32'd1);
            check("bp stall out_data", 32'(out_data), 32'h11);
            check("bp stall out_ch", 32'(out_ch), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", 32'(in_ready), 32'b0010);
        tick();
        in_valid = '0;
        check("bp second out_valid", 32'(out_valid), 32'd1);
        check("bp second out_data", 32'(out_data), 32'h22);
        tick();
        check("bp no duplicate", 32'(out_valid), 32'd0);

        // Mid-stream asynchronous reset
        in_valid  = 4'b0001;
        set_data(0, 8'h33);
        out_ready = 1'b0;
        tick();
        in_valid = '0;
        check("mrst loaded out_valid", 32'(out_valid), 32'd1);
        check("mrst loaded out_data", 32'(out_data), 32'h33);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst async out_valid", 32'(out_valid), 32'd0);
        check("mrst async out_data", 32'(out_data), 32'd0);
        tick();
        rst_n     = 1'b1;
        in_valid  = 4'b1111;
        for (int k = 0; k < NUM_CH; k++) set_data(k, 8'(8'h40 + k));
        out_ready = 1'b1;
        #1;
        check("mrst first grant", 32'(in_ready), 32'b0001);
        tick();
        in_valid = '0;
        check("mrst out_ch", 32'(out_ch), 32'd0);
        check("mrst out_data", 32'(out_data), 32'h40);

`ifdef MUX_FORCE_SEL_EN
        // Forced select leaves the pointer at 1
        tick();
        do_reset();
        in_valid = 4'b0010;
        tick();
        check("force setup out_ch", 32'(out_ch), 32'd1);
        in_valid  = 4'b1111;
        force_en  = 1'b1;
        force_sel = 2'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("force out_ch", 32'(out_ch), 32'd3);
        end
        force_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("force resume out_ch", 32'(out_ch), 32'((2 + i) % 4));
        end
        in_valid = '0;
`endif

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
